// File: rtl/antares_pkg.sv
// Shared definitions for the fetch front end: sequencer states, branch-taken
// encodings, reset vector and small address helpers.
package antares_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [1:0]  BR_TAKEN_A       = 2'b01;
  localparam logic [1:0]  BR_TAKEN_B       = 2'b10;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic branch_taken(input logic [1:0] br);
    return (br == BR_TAKEN_A) || (br == BR_TAKEN_B);
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/redirect_select.sv
// Combinational redirect decision: a new branch beats a new jump, and any new
// request beats a redirect parked earlier in the pending register.
module redirect_select
  import antares_pkg::*;
(
  input  logic [1:0]  branch,
  input  logic        jumpReg,
  input  logic [31:0] branchAdress,
  input  logic [31:0] jumpAdress,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  output logic        redirect,
  output logic [31:0] target
);

  logic taken;

  always_comb begin
    taken    = branch_taken(branch);
    redirect = taken || jumpReg || pend_valid;
    target   = pend_target;
    if (taken)        target = align_word(branchAdress);
    else if (jumpReg) target = align_word(jumpAdress);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the fetch pc, the instruction memory
// request, IF/ID valid and flush, with halt > redirect > stall > sequential.
module fetch_sequencer
  import antares_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  branch,
  input  logic        jumpReg,
  input  logic [31:0] branchAdress,
  input  logic [31:0] jumpAdress,
  input  logic        halt,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        pc_valid,
  output logic        flush,
  output logic        busy_wait,
  output state_e      state_dbg
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        halt_pend_q, halt_pend_d;
  logic        redirect;
  logic [31:0] target;
  logic        halt_eff;

  redirect_select u_sel (
    .branch      (branch),
    .jumpReg     (jumpReg),
    .branchAdress(branchAdress),
    .jumpAdress  (jumpAdress),
    .pend_valid  (pend_q),
    .pend_target (pend_tgt_q),
    .redirect    (redirect),
    .target      (target)
  );

  // halt_pend_q is only ever set while waiting on memory
  assign halt_eff = halt || halt_pend_q;

  // Memory handshake: imem_req is held high in FETCH/WAIT; a cycle with
  // imem_req=1 and imem_ready=1 completes the request for the current pc.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    halt_pend_d = halt_pend_q;
    pc_valid    = 1'b0;
    case (state_q)
      ST_BOOT: state_d = halt ? ST_HALT : ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        if (state_q == ST_WAIT && !imem_ready) begin
          // The selector already prefers a new request over the parked one.
          pend_d      = redirect;
          pend_tgt_d  = target;
          halt_pend_d = halt_pend_q || halt;
        end else begin
          pend_d      = 1'b0;
          halt_pend_d = 1'b0;
          state_d     = ST_FETCH;
          if (halt_eff) begin
            state_d = ST_HALT;
          end else if (redirect) begin
            pc_d    = target;
            cnt_d   = FLUSH_LOAD;
            state_d = ST_FLUSH;
          end else if (!imem_ready) begin
            state_d = ST_WAIT;
          end else if (!stall) begin
            pc_valid = 1'b1;
            pc_d     = pc_q + 32'd4;
          end
        end
      end
      ST_FLUSH: begin
        if (halt) begin
          state_d = ST_HALT;
          cnt_d   = 4'd0;
        end else if (redirect) begin
          pc_d  = target;
          cnt_d = FLUSH_LOAD;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_FETCH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      cnt_q       <= 4'd0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= 32'd0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign pc        = pc_q;
  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign flush     = (state_q == ST_FLUSH);
  assign busy_wait = (state_q == ST_WAIT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, checked
// each cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;
  import antares_pkg::*;

  localparam int FLUSH_N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic        jumpReg = 1'b0;
  logic [31:0] branchAdress = 32'd0;
  logic [31:0] jumpAdress = 32'd0;
  logic        halt = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc;
  logic        imem_req, pc_valid, flush, busy_wait;
  state_e      state_dbg;

  fetch_sequencer #(.RESET_PC(32'h0), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .jumpReg(jumpReg),
    .branchAdress(branchAdress), .jumpAdress(jumpAdress), .halt(halt),
    .imem_ready(imem_ready), .pc(pc), .imem_req(imem_req), .pc_valid(pc_valid),
    .flush(flush), .busy_wait(busy_wait), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch front end
  bit          m_boot, m_halted, m_wait, m_pend, m_halt_pend;
  int          m_flush_left;
  logic [31:0] m_pc, m_pend_tgt;
  bit          s_flush, s_busy, s_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_boot = 1; m_halted = 0; m_wait = 0; m_pend = 0; m_halt_pend = 0;
    m_flush_left = 0; m_pc = 32'h0; m_pend_tgt = 32'h0;
  endfunction

  function automatic bit is_taken(input logic [1:0] b);
    return (b == 2'd1) || (b == 2'd2);
  endfunction

  function automatic logic [31:0] new_target();
    if (is_taken(branch)) return branchAdress & 32'hFFFF_FFFC;
    return jumpAdress & 32'hFFFF_FFFC;
  endfunction

  task automatic check_outputs();
    bit fetching, new_redir, redir, halt_now, exp_valid;
    fetching  = !m_boot && !m_halted && (m_flush_left == 0);
    new_redir = is_taken(branch) || jumpReg;
    redir     = new_redir || (m_wait && m_pend);
    halt_now  = halt || (m_wait && m_halt_pend);
    exp_valid = fetching && imem_ready && !halt_now && !redir && !stall;
    chk("pc", pc, m_pc);
    chk("imem_req", 32'(imem_req), 32'(fetching));
    chk("pc_valid", 32'(pc_valid), 32'(exp_valid));
    chk("flush", 32'(flush), 32'(m_flush_left > 0));
    chk("busy_wait", 32'(busy_wait), 32'(m_wait));
    chk("is_boot", 32'(state_dbg == ST_BOOT), 32'(m_boot));
    chk("is_halt", 32'(state_dbg == ST_HALT), 32'(m_halted));
  endtask

  function automatic void model_step();
    bit new_redir, redir, halt_now;
    logic [31:0] tgt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    new_redir = is_taken(branch) || jumpReg;
    redir     = new_redir || (m_wait && m_pend);
    halt_now  = halt || (m_wait && m_halt_pend);
    tgt       = new_redir ? new_target() : m_pend_tgt;
    if (m_boot) begin
      m_boot = 0;
      if (halt) m_halted = 1;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_flush_left > 0) begin
      if (halt) begin
        m_halted = 1; m_flush_left = 0;
      end else if (new_redir) begin
        m_pc = tgt; m_flush_left = FLUSH_N;
      end else begin
        m_flush_left--;
      end
    end else if (m_wait && !imem_ready) begin
      if (halt) m_halt_pend = 1;
      if (new_redir) begin
        m_pend = 1; m_pend_tgt = tgt;
      end
    end else begin
      m_wait = 0; m_pend = 0; m_halt_pend = 0;
      if (halt_now) m_halted = 1;
      else if (redir) begin
        m_pc = tgt; m_flush_left = FLUSH_N;
      end else if (!imem_ready) m_wait = 1;
      else if (!stall) m_pc = m_pc + 32'd4;
    end
  endfunction

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic cycle();
    #1;
    s_flush = flush; s_busy = busy_wait; s_valid = pc_valid;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit rdy, input bit st, input bit jr, input bit h,
                       input logic [1:0] br, input logic [31:0] ba, input logic [31:0] ja);
    imem_ready = rdy; stall = st; jumpReg = jr; halt = h;
    branch = br; branchAdress = ba; jumpAdress = ja;
    cycle();
  endtask

  task automatic idle(input bit rdy);
    drive(rdy, 0, 0, 0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_boot", 32'(state_dbg == ST_BOOT), 32'd1);
    chk("async_rst_idle", {29'd0, imem_req, flush, busy_wait}, 32'd0);
    model_reset();
    @(negedge clk);
    idle(1);
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_cnt;
    int flush_cnt;
    model_reset();
    @(negedge clk);
    idle(1);
    idle(1);
    rst_n = 1'b1;

    // boot then sequential fetch 0,4
    repeat (3) idle(1);
    chk("seq_pc8", pc, 32'h8);

    // memory wait at pc=8
    busy_cnt = 0;
    repeat (3) begin idle(0); busy_cnt += int'(s_busy); end
    idle(1); busy_cnt += int'(s_busy);
    chk("wait_busy_cycles", busy_cnt, 3);
    chk("wait_valid_on_ready", 32'(s_valid), 32'd1);
    chk("wait_pc12", pc, 32'hC);

    // branch and jump together: branch wins
    drive(1, 0, 1, 0, 2'b10, 32'h40, 32'h80);
    chk("br_pc40", pc, 32'h40);
    flush_cnt = 0;
    repeat (3) begin idle(1); flush_cnt += int'(s_flush); end
    chk("br_flush_cycles", flush_cnt, FLUSH_N);
    chk("br_resume", pc, 32'h44);

    // jump arriving during WAIT is parked until memory is ready
    idle(0);
    drive(0, 0, 1, 0, 2'b00, 32'h0, 32'h103);
    idle(0);
    chk("wait_jr_hold", pc, 32'h44);
    idle(1);
    #1;
    chk("wait_jr_pc", pc, 32'h100);
    chk("wait_jr_flush", 32'(flush), 32'd1);
    idle(1);
    idle(1);

    // 32-bit wrap, then redirect under stall
    drive(1, 0, 1, 0, 2'b00, 32'h0, 32'hFFFF_FFFE);
    idle(1);
    idle(1);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    idle(1);
    chk("wrap_pc0", pc, 32'h0);
    drive(1, 1, 0, 0, 2'b01, 32'h200, 32'h0);
    chk("stall_redirect", pc, 32'h200);
    idle(1);
    idle(1);

    // random traffic
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, 0,
            ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
            $urandom, $urandom);
    end

    // halt during FLUSH
    repeat (5) idle(1);
    drive(1, 0, 1, 0, 2'b00, 32'h0, 32'h300);
    idle(1);
    drive(1, 0, 0, 1, 2'b00, 32'h0, 32'h0);
    repeat (3) idle(1);
    #1;
    chk("halt_state", 32'(state_dbg == ST_HALT), 32'd1);
    chk("halt_idle", {29'd0, imem_req, flush, pc_valid}, 32'd0);
    chk("halt_pc", pc, 32'h300);
    async_reset();
    repeat (3) idle(1);
    chk("post_halt_pc8", pc, 32'h8);

    // halt pulse while waiting takes effect on ready
    idle(0);
    drive(0, 0, 0, 1, 2'b00, 32'h0, 32'h0);
    idle(1);
    chk("wait_halt", 32'(state_dbg == ST_HALT), 32'd1);
    async_reset();

    // reset mid-WAIT with a parked redirect, then mid-FLUSH
    idle(1);
    idle(0);
    drive(0, 0, 1, 0, 2'b00, 32'h0, 32'h500);
    async_reset();
    repeat (3) idle(1);
    chk("rst_wait_pc8", pc, 32'h8);
    drive(1, 0, 0, 0, 2'b01, 32'h600, 32'h0);
    async_reset();
    repeat (4) idle(1);
    chk("rst_flush_pc12", pc, 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
